pid_cfg_writer: RTL and testbench
=================================

// Module: pid_cfg_writer
// PURPOSE
//  Initiator side of the config write bus (wr_en/wr_addr/wr_chan/wr_data) consumed by pid_filter
//  and the other per-channel processing blocks. Accepts host config commands over valid/ready,
//  buffers them in a FIFO and issues them as single-cycle bus writes, one write per clock.
//  Expands broadcast commands into one write per channel. Drops and counts commands that target
//  channels which do not exist.
// PARAMETERS
//  N_CHAN      8         number of processing channels; valid wr_chan values are 0..N_CHAN-1
//  W_WR_ADDR   16        config address width
//  W_WR_CHAN   16        config channel field width
//  W_WR_DATA   48        config data width
//  FIFO_DEPTH  8         command FIFO entries; must be a power of 2 and >= 2
//  BCAST_CHAN  all-ones  cmd_chan value meaning "all channels", i.e. {W_WR_CHAN{1'b1}}
// PORTS
//  clk_in         in   1          system clock
//  rst_n_in       in   1          reset, asynchronous, active-low
//  cmd_valid_in   in   1          host command valid
//  cmd_ready_out  out  1          command accepted when valid && ready at a rising edge
//  cmd_addr_in    in   W_WR_ADDR  target config address
//  cmd_chan_in    in   W_WR_CHAN  target channel, or BCAST_CHAN
//  cmd_data_in    in   W_WR_DATA  write data
//  wr_en          out  1          one-cycle write strobe
//  wr_addr        out  W_WR_ADDR  write address
//  wr_chan        out  W_WR_CHAN  write channel
//  wr_data        out  W_WR_DATA  write data
//  busy_out       out  1          high while the FIFO is non-empty or the FSM is not IDLE
//  drop_cnt_out   out  16         count of dropped commands; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (rst_n_in low, asynchronous): every output is 0, including cmd_ready_out; FIFO is
//    emptied; FSM goes to IDLE; drop count is cleared. cmd_ready_out rises on the first edge
//    after reset is released.
//  - All bus outputs are registered. wr_addr, wr_chan and wr_data hold the last issued values
//    while wr_en is low.
//  - cmd_ready_out = !fifo_full, registered. There is no bypass: a push while full is not
//    accepted even if a pop occurs in the same cycle.
//  - FIFO is first-word-fall-through. A command accepted at edge k into an empty FIFO with the
//    FSM in IDLE produces wr_en high for the cycle after edge k+2 (latency 2).
//  - FSM states and transitions:
//      IDLE:  FIFO empty -> stay in IDLE.
//             Head chan < N_CHAN -> pop, issue one write, stay in IDLE (1 write per clock).
//             Head chan == BCAST_CHAN -> pop, latch addr/data, issue chan 0, go to BCAST with
//             idx=1.
//             Otherwise -> pop, no write, drop_cnt += 1, stay in IDLE.
//      BCAST: issue (latched addr, chan=idx, latched data) each clock; idx += 1.
//             When idx == N_CHAN-1 is issued, go to IDLE.
//             The FIFO is not popped in BCAST, but it still accepts pushes.
//  - Broadcast issues exactly N_CHAN consecutive writes, channels ascending, with no gaps.
//    If N_CHAN == 1, BCAST is skipped.
//  - wr_chan is zero-extended from the internal index. Comparisons are unsigned. The width of
//    idx is $clog2(N_CHAN)+1 so the compare does not wrap.
//  - Back-to-back commands produce back-to-back wr_en with no idle cycle between them.
//  - Order is strictly FIFO. Broadcast expansion completes before the next command is popped.
//  - Reset mid-broadcast aborts immediately: no further wr_en is issued and the remaining
//    channels are not written.
//  - Address is not decoded. Every address, including the clear-request address, is forwarded
//    unchanged. Responders ignore addresses they do not own.
// STRUCTURE
//  - Write-bus address constants stay in ep_map.vh.
//  - BCAST_CHAN and the FSM state encodings go in a shared header, pid_cfg_defs.vh, for reuse by
//    responders and benches.
//  - One sub-module: cfg_cmd_fifo. It is a synchronous first-word-fall-through FIFO with ports
//    push/pop/full/empty, width W_WR_ADDR+W_WR_CHAN+W_WR_DATA and depth FIFO_DEPTH, with an
//    asynchronous active-low reset.
//  - The FSM, broadcast counter, drop counter and output registers live in the top module.
// TESTING
//  1. Single write: cmd (addr=16'h0020, chan=3, data=48'h1234) into an idle block -> wr_en is
//     high for 1 cycle, 2 cycles after acceptance, with the same addr/chan/data. busy_out then
//     returns to 0.
//  2. Broadcast: chan=16'hFFFF, addr=16'h0021, data=5, N_CHAN=8 -> 8 consecutive wr_en cycles
//     with wr_chan 0..7 and addr/data constant.
//  3. Fill and backpressure: 12 commands presented back-to-back with FIFO_DEPTH=8 ->
//     cmd_ready_out drops while the FIFO is full. All 12 writes are issued in order, with no loss
//     and no duplication.
//  4. Out-of-range channel: chan=8 with N_CHAN=8 -> no wr_en and drop_cnt_out=1. A following
//     valid command is issued normally. After 70000 drops the count reads 16'hFFFF.
//  5. Reset mid-broadcast: rst_n_in is pulled low after chan 2 is issued -> all outputs are 0
//     immediately, no further writes occur, and the FIFO is empty after release.
//  6. Broadcast followed by a queued unicast (chan=1) -> 8 broadcast writes, then the chan-1
//     write on the next cycle, with no gap.

Source files
------------

// File: rtl/pid_cfg_writer_pkg.sv
// Shared types and constants for the pid_cfg_writer config-write initiator.
// Responders and benches import this for the bus widths and the broadcast channel code.
package pid_cfg_writer_pkg;

  localparam int DEF_N_CHAN     = 8;
  localparam int DEF_FIFO_DEPTH = 8;

  localparam int W_WR_ADDR = 16;
  localparam int W_WR_CHAN = 16;
  localparam int W_WR_DATA = 48;
  localparam int W_CMD     = W_WR_ADDR + W_WR_CHAN + W_WR_DATA;

  localparam logic [W_WR_CHAN-1:0] BCAST_CHAN = {W_WR_CHAN{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BCAST = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [W_WR_ADDR-1:0] addr;
    logic [W_WR_CHAN-1:0] chan;
    logic [W_WR_DATA-1:0] data;
  } cfg_cmd_t;

endpackage

// File: rtl/pid_cfg_writer_if.sv
// Host command handshake plus the config write bus driven towards the per-channel blocks.
// master = the writer (pid_cfg_writer); slave = host and responders taken together.
interface pid_cfg_writer_if;
  import pid_cfg_writer_pkg::*;

  logic                 cmd_valid_in;
  logic                 cmd_ready_out;
  logic [W_WR_ADDR-1:0] cmd_addr_in;
  logic [W_WR_CHAN-1:0] cmd_chan_in;
  logic [W_WR_DATA-1:0] cmd_data_in;

  logic                 wr_en;
  logic [W_WR_ADDR-1:0] wr_addr;
  logic [W_WR_CHAN-1:0] wr_chan;
  logic [W_WR_DATA-1:0] wr_data;

  modport master (
    input  cmd_valid_in, cmd_addr_in, cmd_chan_in, cmd_data_in,
    output cmd_ready_out, wr_en, wr_addr, wr_chan, wr_data
  );

  modport slave (
    output cmd_valid_in, cmd_addr_in, cmd_chan_in, cmd_data_in,
    input  cmd_ready_out, wr_en, wr_addr, wr_chan, wr_data
  );

endinterface

// File: rtl/pid_cfg_writer_fifo.sv
// cfg_cmd_fifo: first-word-fall-through command FIFO with a registered head stage.
// A pushed word becomes visible at the head one clock after it is written.
module cfg_cmd_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             drained
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic             head_valid_q, full_q;
  logic             push_ok, pop_ok, load;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && head_valid_q;
  // Refill the head from storage whenever it is free or being consumed this cycle.
  assign load    = (wr_ptr_q != rd_ptr_q) && (!head_valid_q || pop_ok);
  assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);

  // NOTE: storage and head data carry no reset; the pointers and valid flag alone define contents.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
    if (load)    dout <= mem[rd_ptr_q[AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (load)    rd_ptr_q <= rd_ptr_q + CW'(1);
      if (load)        head_valid_q <= 1'b1;
      else if (pop_ok) head_valid_q <= 1'b0;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  assign full    = full_q;
  assign empty   = !head_valid_q;
  assign drained = (count_q == '0);

endmodule

// File: rtl/pid_cfg_writer.sv
// Config write initiator: queues host commands and issues one registered bus write per clock,
// expanding broadcasts to every channel and dropping (and counting) out-of-range channels.
module pid_cfg_writer
  import pid_cfg_writer_pkg::*;
#(
  parameter int N_CHAN     = DEF_N_CHAN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  pid_cfg_writer_if.master     bus,
  output logic                 busy_out,
  output logic [15:0]          drop_cnt_out
);
  localparam int                   IW       = $clog2(N_CHAN) + 1;
  localparam logic [W_WR_CHAN-1:0] N_CHAN_W = W_WR_CHAN'(N_CHAN);

  wr_state_e            state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [W_WR_ADDR-1:0] lat_addr_q, lat_addr_d;
  logic [W_WR_DATA-1:0] lat_data_q, lat_data_d;
  logic [15:0]          drop_cnt_q;
  logic                 drop_inc;
  logic                 rdy_en_q;

  logic                 wr_en_q, wr_en_d;
  logic [W_WR_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [W_WR_CHAN-1:0] wr_chan_q, wr_chan_d;
  logic [W_WR_DATA-1:0] wr_data_q, wr_data_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drained;
  logic [W_CMD-1:0]     fifo_dout;
  cfg_cmd_t             head;

  // Ready comes straight from flops; the FIFO's full flag is exact for the current occupancy.
  assign bus.cmd_ready_out = rdy_en_q && !fifo_full;
  assign fifo_push         = bus.cmd_valid_in && bus.cmd_ready_out;
  assign head              = cfg_cmd_t'(fifo_dout);

  cfg_cmd_fifo #(.WIDTH(W_CMD), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .push    (fifo_push),
    .din     ({bus.cmd_addr_in, bus.cmd_chan_in, bus.cmd_data_in}),
    .full    (fifo_full),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .drained (fifo_drained)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    fifo_pop   = 1'b0;
    drop_inc   = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_chan_d  = wr_chan_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.chan < N_CHAN_W) begin
            wr_en_d   = 1'b1;
            wr_addr_d = head.addr;
            wr_chan_d = head.chan;
            wr_data_d = head.data;
          end else if (head.chan == BCAST_CHAN) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = head.addr;
            wr_chan_d  = '0;
            wr_data_d  = head.data;
            lat_addr_d = head.addr;
            lat_data_d = head.data;
            if (N_CHAN > 1) begin
              state_d = ST_BCAST;
              idx_d   = IW'(1);
            end
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_BCAST: begin
        wr_en_d   = 1'b1;
        wr_addr_d = lat_addr_q;
        wr_chan_d = W_WR_CHAN'(idx_q);
        wr_data_d = lat_data_q;
        idx_d     = idx_q + IW'(1);
        if (idx_q == IW'(N_CHAN - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      drop_cnt_q <= '0;
      rdy_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_chan_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      rdy_en_q   <= 1'b1;
      if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_chan_q  <= wr_chan_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_chan = wr_chan_q;
  assign bus.wr_data = wr_data_q;
  assign busy_out     = !fifo_drained || (state_q != ST_IDLE);
  assign drop_cnt_out = drop_cnt_q;

endmodule

// File: tb/tb_pid_cfg_writer.sv
// Scoreboard bench for pid_cfg_writer: stimulus pushes expected writes, a negedge monitor
// pops and compares every wr_en cycle.
module tb_pid_cfg_writer;
  import pid_cfg_writer_pkg::*;

  logic        clk_in   = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        busy_out;
  logic [15:0] drop_cnt_out;

  pid_cfg_writer_if bus ();

  pid_cfg_writer #(.N_CHAN(8), .FIFO_DEPTH(8)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .bus         (bus),
    .busy_out    (busy_out),
    .drop_cnt_out(drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          last_acc_cyc = 0;
  bit          saw_not_ready = 1'b0;
  logic [79:0] exp_q[$];
  int          wr_cyc_log[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (rst_n_in && bus.wr_en === 1'b1) begin
      wr_count++;
      wr_cyc_log.push_back(cyc);
      if (exp_q.size() == 0) check("wr_unexpected", 80'(bus.wr_en), 80'd0);
      else check("wr_fields", {bus.wr_addr, bus.wr_chan, bus.wr_data}, exp_q.pop_front());
    end
  end

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic send(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
    int waited = 0;
    bus.cmd_valid_in = 1'b1;
    bus.cmd_addr_in  = a;
    bus.cmd_chan_in  = c;
    bus.cmd_data_in  = d;
    while (bus.cmd_ready_out !== 1'b1 && waited < 100) begin
      saw_not_ready = 1'b1;
      @(negedge clk_in);
      waited++;
    end
    if (bus.cmd_ready_out !== 1'b1) check("accept_timeout", 80'(bus.cmd_ready_out), 80'd1);
    @(posedge clk_in);
    @(negedge clk_in);
    last_acc_cyc     = cyc;
    bus.cmd_valid_in = 1'b0;
    if (c < 16'd8) exp_q.push_back({a, c, d});
    else if (c == 16'hFFFF) for (int i = 0; i < 8; i++) exp_q.push_back({a, 16'(i), d});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_out !== 1'b0) && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    repeat (4) @(negedge clk_in);
    check(name, 80'(exp_q.size()), 80'd0);
  endtask

  task automatic check_run(input string name, input int first, input int n);
    int gaps = 0;
    for (int i = first + 1; i < first + n && i < wr_cyc_log.size(); i++)
      if (wr_cyc_log[i] != wr_cyc_log[i-1] + 1) gaps++;
    check(name, 80'(gaps), 80'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, base, acc, n;
    bit found;
    bus.cmd_valid_in = 1'b0;
    bus.cmd_addr_in  = '0;
    bus.cmd_chan_in  = '0;
    bus.cmd_data_in  = '0;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_wr_en", 80'(bus.wr_en), 80'd0);
    check("rst_wr_fields", {bus.wr_addr, bus.wr_chan, bus.wr_data}, 80'd0);
    check("rst_ready", 80'(bus.cmd_ready_out), 80'd0);
    check("rst_busy", 80'(busy_out), 80'd0);
    check("rst_drop", 80'(drop_cnt_out), 80'd0);
    rst_n_in = 1'b1;
    #1;
    check("rel_ready_low", 80'(bus.cmd_ready_out), 80'd0);
    @(negedge clk_in);
    check("rel_ready_high", 80'(bus.cmd_ready_out), 80'd1);

    // 1. Single write, latency 2, busy returns low
    w0 = wr_count; base = wr_cyc_log.size();
    send(16'h0020, 16'd3, 48'h1234);
    acc = last_acc_cyc;
    check("t1_busy_high", 80'(busy_out), 80'd1);
    wait_drain("t1_drain");
    check("t1_count", 80'(wr_count - w0), 80'd1);
    if (wr_cyc_log.size() > base) check("t1_latency", 80'(wr_cyc_log[base] - acc), 80'd2);
    check("t1_busy_low", 80'(busy_out), 80'd0);
    check("t1_hold", {bus.wr_addr, bus.wr_chan, bus.wr_data}, {16'h0020, 16'd3, 48'h1234});

    // 2. Broadcast to all 8 channels, consecutive
    w0 = wr_count; base = wr_cyc_log.size();
    send(16'h0021, 16'hFFFF, 48'd5);
    wait_drain("t2_drain");
    check("t2_count", 80'(wr_count - w0), 80'd8);
    check_run("t2_no_gap", base, 8);

    // 3. Backpressure: broadcast stalls pops while 12 unicasts fill the FIFO
    w0 = wr_count; saw_not_ready = 1'b0;
    send(16'h0030, 16'hFFFF, 48'hAA);
    for (int i = 0; i < 12; i++) send(16'h0100 + 16'(i), 16'(i % 8), 48'h5000 + 48'(i));
    wait_drain("t3_drain");
    check("t3_ready_dropped", 80'(saw_not_ready), 80'd1);
    check("t3_count", 80'(wr_count - w0), 80'd20);

    // 6. Broadcast then queued unicast chan 1, no gap
    w0 = wr_count; base = wr_cyc_log.size();
    send(16'h0031, 16'hFFFF, 48'h0BCA);
    send(16'h0032, 16'd1, 48'h0C01);
    wait_drain("t6_drain");
    check("t6_count", 80'(wr_count - w0), 80'd9);
    check_run("t6_no_gap", base, 9);

    // 4. Out-of-range channels, boundary channel 7, saturation
    w0 = wr_count;
    send(16'h0040, 16'd8, 48'h1);
    wait_drain("t4_drain_a");
    check("t4_drop1", 80'(drop_cnt_out), 80'd1);
    check("t4_no_write", 80'(wr_count - w0), 80'd0);
    send(16'h0041, 16'd7, 48'h2);
    send(16'h0042, 16'hFFFE, 48'h3);
    wait_drain("t4_drain_b");
    check("t4_chan7_written", 80'(wr_count - w0), 80'd1);
    check("t4_drop2", 80'(drop_cnt_out), 80'd2);
    for (int i = 0; i < 70000; i++) send(16'h0043, 16'd9, 48'(i));
    wait_drain("t4_drain_c");
    check("t4_saturate", 80'(drop_cnt_out), 80'hFFFF);

    // 5. Reset mid-broadcast with a unicast queued behind it
    send(16'h0022, 16'hFFFF, 48'h77);
    send(16'h0023, 16'd4, 48'h99);
    n = 0; found = 1'b0;
    while (!found && n < 50) begin
      if (bus.wr_en === 1'b1 && bus.wr_chan == 16'd2) found = 1'b1;
      else begin
        @(negedge clk_in);
        n++;
      end
    end
    check("t5_chan2_seen", 80'(found), 80'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("t5_wr_en", 80'(bus.wr_en), 80'd0);
    check("t5_wr_fields", {bus.wr_addr, bus.wr_chan, bus.wr_data}, 80'd0);
    check("t5_ready", 80'(bus.cmd_ready_out), 80'd0);
    check("t5_busy", 80'(busy_out), 80'd0);
    check("t5_drop", 80'(drop_cnt_out), 80'd0);
    exp_q.delete();
    w0 = wr_count;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in);
    check("t5_no_writes", 80'(wr_count - w0), 80'd0);
    check("t5_busy_after", 80'(busy_out), 80'd0);
    check("t5_ready_after", 80'(bus.cmd_ready_out), 80'd1);
    send(16'h0024, 16'd6, 48'h55);
    wait_drain("t5_drain");
    check("t5_fresh_count", 80'(wr_count - w0), 80'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
